// File: rtl/writeback_arbiter_if.sv
// ============================================================================
//  Module      : writeback_arbiter_if
//  Description : Bundle of the write-back requester and register-file write
//                signals around writeback_arbiter.
//                  req       [5:0]  per-requester write pending
//                  req_dest  [29:0] requester i destination in [5i+4:5i]
//                  wb_hold          freeze arbitration
//                  grant     [5:0]  one-hot grant (registered)
//                  mux_sel   [2:0]  write-data mux selector (registered)
//                  reg_write        register-file write enable (registered)
//                  write_reg [4:0]  destination register (registered)
//                  stall            pending requests left ungranted
//                master : requester/control side, slave : arbiter side.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface writeback_arbiter_if;
    logic [5:0]  req;
    logic [29:0] req_dest;
    logic        wb_hold;
    logic [5:0]  grant;
    logic [2:0]  mux_sel;
    logic        reg_write;
    logic [4:0]  write_reg;
    logic        stall;

    modport master (
        output req, req_dest, wb_hold,
        input  grant, mux_sel, reg_write, write_reg, stall
    );

    modport slave (
        input  req, req_dest, wb_hold,
        output grant, mux_sel, reg_write, write_reg, stall
    );
endinterface

`default_nettype wire

// File: rtl/writeback_arbiter.sv
// ============================================================================
//  Module      : writeback_arbiter
//  Description : Six-requester register-file write-back arbiter. One eligible
//                requester is granted per cycle, outputs registered
//                (latency 1). A requester granted this cycle is masked at the
//                next sampling edge. Destination register 0 completes the
//                handshake without a register-file write.
//  Ports       : clk    - clock, rising edge
//                reset  - asynchronous active-high reset
//                bus    - writeback_arbiter_if.slave (req/req_dest/wb_hold in,
//                         grant/mux_sel/reg_write/write_reg/stall out)
//  Config      : WB_FIXED_PRIO_EN defined  -> fixed priority, lowest index wins
//                WB_FIXED_PRIO_EN undefined -> round-robin from last grant + 1
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module writeback_arbiter (
    input  wire logic          clk,
    input  wire logic          reset,
    writeback_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        HELD  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [5:0]  r_grant;
    logic [2:0]  r_mux_sel;
    logic        r_reg_write;
    logic [4:0]  r_write_reg;
    logic        r_stall;

    logic [5:0]  w_grant_nxt;
    logic [2:0]  w_mux_sel_nxt;
    logic        w_reg_write_nxt;
    logic [4:0]  w_write_reg_nxt;
    logic        w_stall_nxt;

    logic [5:0]  w_elig;
    logic        w_found;
    logic [2:0]  w_idx;
    logic [5:0]  w_onehot;
    logic [4:0]  w_dest;

    // The requester holding the grant right now still has req high at the
    // next edge (it drops req one cycle after seeing grant), so mask it.
    assign w_elig = bus.req & ~r_grant;

`ifdef WB_FIXED_PRIO_EN
    // Descending scan so the lowest eligible index is the last one written.
    always_comb begin
        w_found = 1'b0;
        w_idx   = 3'd0;
        for (int i = 5; i >= 0; i--) begin
            if (w_elig[i]) begin
                w_found = 1'b1;
                w_idx   = 3'(i);
            end
        end
    end
`else
    // Index of the last grant; reset to 5 so index 0 is searched first.
    logic [2:0]  r_ptr;
    logic [3:0]  w_cand;

    // Search order: r_ptr+1, r_ptr+2, ... wrapping 5 -> 0.
    always_comb begin
        w_found = 1'b0;
        w_idx   = 3'd0;
        w_cand  = 4'd0;
        for (int off = 1; off <= 6; off++) begin
            w_cand = {1'b0, r_ptr} + 4'(off);
            if (w_cand >= 4'd6) begin
                w_cand = w_cand - 4'd6;
            end
            if (!w_found && w_elig[w_cand[2:0]]) begin
                w_found = 1'b1;
                w_idx   = w_cand[2:0];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr <= 3'd5;
        end else if ((w_state_nxt == WRITE) && w_found) begin
            r_ptr <= w_idx;
        end
    end
`endif

    assign w_onehot = 6'b000001 << w_idx;

    always_comb begin
        w_dest = 5'd0;
        for (int i = 0; i < 6; i++) begin
            if (w_idx == 3'(i)) begin
                w_dest = bus.req_dest[i*5 +: 5];
            end
        end
    end

    // Next-state / next-output logic. wb_hold always wins over pending
    // requests. Leaving HELD re-arbitrates on the same edge so a request that
    // waited out the hold is granted one cycle after wb_hold drops; with
    // nothing eligible it settles in IDLE.
    always_comb begin
        w_state_nxt     = IDLE;
        w_grant_nxt     = 6'd0;
        w_reg_write_nxt = 1'b0;
        w_mux_sel_nxt   = r_mux_sel;
        w_write_reg_nxt = r_write_reg;
        w_stall_nxt     = 1'b0;

        case (r_state)
            IDLE, WRITE, HELD: begin
                if (bus.wb_hold) begin
                    w_state_nxt = HELD;
                    w_stall_nxt = |w_elig;
                end else if (w_found) begin
                    w_state_nxt     = WRITE;
                    w_grant_nxt     = w_onehot;
                    w_mux_sel_nxt   = w_idx;
                    w_write_reg_nxt = w_dest;
                    w_reg_write_nxt = (w_dest != 5'd0);
                    w_stall_nxt     = |(w_elig & ~w_onehot);
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_grant     <= 6'd0;
            r_mux_sel   <= 3'd0;
            r_reg_write <= 1'b0;
            r_write_reg <= 5'd0;
            r_stall     <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_grant     <= w_grant_nxt;
            r_mux_sel   <= w_mux_sel_nxt;
            r_reg_write <= w_reg_write_nxt;
            r_write_reg <= w_write_reg_nxt;
            r_stall     <= w_stall_nxt;
        end
    end

    assign bus.grant     = r_grant;
    assign bus.mux_sel   = r_mux_sel;
    assign bus.reg_write = r_reg_write;
    assign bus.write_reg = r_write_reg;
    assign bus.stall     = r_stall;

endmodule

`default_nettype wire

// File: tb/tb_writeback_arbiter.sv
// ============================================================================
//  Module      : tb_writeback_arbiter
//  Description : Directed self-checking bench for writeback_arbiter.
//                Honours WB_FIXED_PRIO_EN for priority-dependent expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_writeback_arbiter;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    writeback_arbiter_if bus ();

    writeback_arbiter u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_dest(input int idx, input logic [4:0] d);
        bus.req_dest[idx*5 +: 5] = d;
    endtask

    task automatic chk_out(input string tag, input logic [5:0] g, input logic [2:0] m,
                           input logic rw, input logic [4:0] wr, input logic st);
        chk({tag, ".grant"},     32'(bus.grant),     32'(g));
        chk({tag, ".mux_sel"},   32'(bus.mux_sel),   32'(m));
        chk({tag, ".reg_write"}, 32'(bus.reg_write), 32'(rw));
        chk({tag, ".write_reg"}, 32'(bus.write_reg), 32'(wr));
        chk({tag, ".stall"},     32'(bus.stall),     32'(st));
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        reset        = 1'b1;
        bus.req      = 6'd0;
        bus.req_dest = 30'd0;
        bus.wb_hold  = 1'b0;

        #12;
        chk_out("reset", 6'b000000, 3'd0, 1'b0, 5'd0, 1'b0);
        reset = 1'b0;

        // Two requesters after reset: round-robin starts at index 0.
        set_dest(0, 5'd3);
        set_dest(5, 5'd17);
        bus.req = 6'b100001;
        tick();
        chk_out("rr_first", 6'b000001, 3'd0, 1'b1, 5'd3, 1'b1);
        bus.req = 6'b100000;
        tick();
        chk_out("rr_second", 6'b100000, 3'd5, 1'b1, 5'd17, 1'b0);
        bus.req = 6'b000000;
        tick();
        chk_out("rr_idle", 6'b000000, 3'd5, 1'b0, 5'd17, 1'b0);

        // Single write; req still high at the next edge is masked.
        set_dest(0, 5'd8);
        bus.req = 6'b000001;
        tick();
        chk_out("single", 6'b000001, 3'd0, 1'b1, 5'd8, 1'b0);
        tick();
        chk_out("single_mask", 6'b000000, 3'd0, 1'b0, 5'd8, 1'b0);
        bus.req = 6'b000000;
        tick();

        // Destination register 0: grant without a write.
        set_dest(2, 5'd0);
        bus.req = 6'b000100;
        tick();
        chk_out("dest0", 6'b000100, 3'd2, 1'b0, 5'd0, 1'b0);
        bus.req = 6'b000000;
        tick();

        // Hold beats a pending request for three cycles.
        set_dest(4, 5'd9);
        bus.wb_hold = 1'b1;
        bus.req     = 6'b010000;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk_out($sformatf("hold%0d", c), 6'b000000, 3'd2, 1'b0, 5'd0, 1'b1);
        end
        bus.wb_hold = 1'b0;
        tick();
        chk_out("hold_release", 6'b010000, 3'd4, 1'b1, 5'd9, 1'b0);
        bus.req = 6'b000000;
        tick();

        // Move the pointer to 1, then contend 1 vs 3.
        set_dest(1, 5'd6);
        bus.req = 6'b000010;
        tick();
        chk_out("ptr1", 6'b000010, 3'd1, 1'b1, 5'd6, 1'b0);
        bus.req = 6'b000000;
        tick();
        set_dest(3, 5'd12);
        bus.req = 6'b001010;
        tick();
`ifdef WB_FIXED_PRIO_EN
        chk_out("prio_a", 6'b000010, 3'd1, 1'b1, 5'd6, 1'b1);
        bus.req = 6'b001000;
        tick();
        chk_out("prio_b", 6'b001000, 3'd3, 1'b1, 5'd12, 1'b0);
`else
        chk_out("prio_a", 6'b001000, 3'd3, 1'b1, 5'd12, 1'b1);
        bus.req = 6'b000010;
        tick();
        chk_out("prio_b", 6'b000010, 3'd1, 1'b1, 5'd6, 1'b0);
`endif
        bus.req = 6'b000000;
        tick();

        // Asynchronous reset while a write is on the outputs.
        bus.req = 6'b000001;
        tick();
        chk("pre_reset.reg_write", 32'(bus.reg_write), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk_out("async_reset", 6'b000000, 3'd0, 1'b0, 5'd0, 1'b0);
        reset   = 1'b0;
        bus.req = 6'b000000;
        tick();

        // Pointer back at 5 after reset: index 0 wins over 5 again.
        bus.req = 6'b100001;
        tick();
        chk_out("post_reset", 6'b000001, 3'd0, 1'b1, 5'd8, 1'b1);
        bus.req = 6'b000000;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/writeback_arbiter.md
WRITEBACK_ARBITER -- requirements
Module: writeback_arbiter

Interface
REQ-001 The block SHALL have no parameters; six requesters fixed, one per write-data mux input (index i drives mux selector value i).
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-004 req  input  6  bit i = requester i has a register-file write pending.
REQ-005 req_dest  input  30  requester i destination register in bits [5i+4:5i].
REQ-006 wb_hold  input  1  control unit freezes arbitration (e.g. during memory stall).
REQ-007 grant  output  6  one-hot, registered; bit i high for exactly one cycle per serviced write.
REQ-008 mux_sel  output  3  registered selector to the write-data mux, value = granted index.
REQ-009 reg_write  output  1  registered register-file write enable.
REQ-010 write_reg  output  5  registered destination register number.
REQ-011 stall  output  1  registered; high when requests exist that were not granted this cycle.

Function
REQ-012 States SHALL be IDLE, WRITE and HELD; IDLE->WRITE on any eligible req with wb_hold low; WRITE->WRITE if another eligible req, else ->IDLE; any state->HELD when wb_hold high; HELD->IDLE when wb_hold low.
REQ-013 Eligible set SHALL be req masked by the current grant (the requester granted this cycle is ineligible at the next sampling edge).
REQ-014 Arbitration SHALL pick one eligible requester per cycle, outputs valid the cycle after sampling (latency 1).
REQ-015 In WRITE: grant[k]=1, mux_sel=k, write_reg=req_dest[k], reg_write=1 unless that dest is 0.
REQ-016 Dest register 0 SHALL be granted (handshake completes) with reg_write=0.
REQ-017 Requester handshake: hold req and req_dest stable until grant seen; drop req the cycle after grant; re-raising later is a new request.
REQ-018 In IDLE and HELD: grant=0, reg_write=0; mux_sel and write_reg hold last values.
REQ-019 wb_hold asserted in the same cycle as eligible reqs SHALL win: no grant issued, requests stay pending.
REQ-020 stall SHALL be 1 when, after the arbitration decision, at least one eligible req remains ungranted (including all eligible reqs during HELD).
REQ-021 Round-robin pointer (3 bits, values 0-5) SHALL start search at last granted index +1, wrapping 5->0; pointer updates only on a grant.

Reset
REQ-022 On reset: state IDLE, grant=0, mux_sel=0, reg_write=0, write_reg=0, stall=0, pointer=5 (so index 0 is searched first).
REQ-023 Reset mid-WRITE SHALL drop reg_write and grant immediately (asynchronously); in-flight request is lost and must be re-raised/held by requester.

Configuration
REQ-024 Macro WB_FIXED_PRIO_EN: defined -> fixed priority, lowest eligible index wins, pointer unused; undefined -> round-robin per REQ-021.

Verification
REQ-025 reset then req=6'b000001, dest0=5'd8 -> next cycle grant=000001, mux_sel=0, reg_write=1, write_reg=8; following cycle IDLE.
REQ-026 req=6'b100001 held until granted, round-robin -> grant 000001 then 100000 on consecutive cycles, stall=1 in first WRITE cycle only.
REQ-027 req=6'b000100, dest2=0 -> grant=000100, reg_write=0.
REQ-028 wb_hold=1 with req=6'b010000 for 3 cycles -> grant=0, stall=1; wb_hold=0 -> grant=010000 one cycle later.
REQ-029 reset pulse while reg_write=1 -> reg_write=0 before next clk edge, all outputs at reset values.
REQ-030 WB_FIXED_PRIO_EN defined, req=6'b001010 held -> grant 000010 before 001000; undefined with pointer=1 -> 001000 first.
